irq_bus_mover: RTL and testbench

IRQ_BUS_MOVER -- requirements
Module: irq_bus_mover

---
 rtl/irqm_pkg.sv | 27 ++
 rtl/irqm_arbiter.sv | 44 ++++
 rtl/irq_bus_mover.sv | 217 +++++++++++++++++++++
 tb/tb_irq_bus_mover.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irqm_pkg.sv
// irqm_pkg: shared types and widths for the interrupt-driven bus mover.
// Holds the FSM state encoding, the channel-index width, the err_ch width,
// the timeout counter width and a helper for round-robin pointer wrap.
package irqm_pkg;

  // Channel indices cover up to 16 channels.
  localparam int CH_IDX_W  = 4;
  localparam int ERR_CH_W  = 4;
  localparam int TMO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    WR   = 2'd3
  } irqm_state_t;

  // Index of the channel after idx, wrapping to 0 past the last channel.
  function automatic logic [CH_IDX_W-1:0] next_ch(input logic [CH_IDX_W-1:0] idx,
                                                  input int nch);
    if (int'(idx) >= nch - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/irqm_arbiter.sv
// irqm_arbiter: picks one requesting channel per cycle.
// Build option IRQM_RR_EN: when defined the search starts at ptr (the
// channel after the last grant, round-robin); when undefined the lowest
// requesting index always wins and ptr is ignored.
module irqm_arbiter
  import irqm_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]      req,
  input  logic [CH_IDX_W-1:0] ptr,
  output logic [NCH-1:0]      grant,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                grant_valid
);

  logic [CH_IDX_W-1:0] start;

`ifdef IRQM_RR_EN
  assign start = (int'(ptr) < NCH) ? ptr : '0;
`else
  logic unused_ptr;
  assign start      = '0;
  assign unused_ptr = ^ptr;
`endif

  // Walk the channels from start, wrapping, and take the first requester.
  always_comb begin
    int j;
    j           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      j = (int'(start) + i) % NCH;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = CH_IDX_W'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_bus_mover.sv
// irq_bus_mover: on an interrupt edge, reads one word from the channel's
// source address, writes it to the channel's destination address, then
// pulses completion and a PC redirect to the channel's ISR vector.
// A read that never returns is abandoned after TMO_CYC wait cycles with
// an err pulse. Build option IRQM_RR_EN selects round-robin arbitration
// (default build: fixed priority, lowest channel first).
module irq_bus_mover
  import irqm_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter int          AW         = 64,
  parameter int          DW         = 64,
  parameter int          TMO_CYC    = 255,
  parameter logic [63:0] VEC_BASE   = 64'd0,
  parameter int          VEC_STRIDE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      irq_req,
  input  logic [NCH-1:0]      irq_mask,
  input  logic [NCH*AW-1:0]   cfg_src_addr,
  input  logic [NCH*AW-1:0]   cfg_dst_addr,
  output logic [AW-1:0]       bus_address,
  output logic [DW-1:0]       bus_write_data,
  output logic                bus_write_enable,
  output logic                bus_read_enable,
  input  logic [DW-1:0]       bus_read_data,
  input  logic                bus_read_valid,
  output logic [NCH-1:0]      irq_done,
  output logic                redirect,
  output logic [AW-1:0]       redirect_pc,
  output logic                busy,
  output logic                err,
  output logic [ERR_CH_W-1:0] err_ch
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_CYC - 1);

  irqm_state_t state_q, state_d;

  logic [NCH-1:0]       irq_prev_q;
  logic                 armed_q;
  logic [NCH-1:0]       pending_q;
  logic [NCH-1:0]       irq_edge;
  logic [NCH-1:0]       clr_mask;
  logic [CH_IDX_W-1:0]  ch_q;
  logic [CH_IDX_W-1:0]  rr_ptr_q;
  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic [DW-1:0]        rd_data_q;
  logic                 err_q;
  logic [ERR_CH_W-1:0]  err_ch_q;

  logic [NCH-1:0]       arb_grant;
  logic [CH_IDX_W-1:0]  arb_idx;
  logic                 arb_valid;

  logic                 take_grant;
  logic                 capture;
  logic                 timeout;
  logic                 finish;

  logic [AW-1:0]        src_sel;
  logic [AW-1:0]        dst_sel;
  logic [NCH-1:0]       ch_onehot;
  logic [63:0]          vec_full;

  // armed_q masks the first sample after reset so levels already high at
  // release are taken as the baseline rather than as edges.
  assign irq_edge = irq_req & ~irq_prev_q & {NCH{armed_q}};
  assign clr_mask = (finish || timeout) ? ch_onehot : '0;

  irqm_arbiter #(
    .NCH(NCH)
  ) u_arbiter (
    .req        (pending_q & irq_mask),
    .ptr        (rr_ptr_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  // Look up the latched channel's addresses and one-hot code.
  always_comb begin
    src_sel   = '0;
    dst_sel   = '0;
    ch_onehot = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_IDX_W'(k)) begin
        src_sel      = cfg_src_addr[k*AW +: AW];
        dst_sel      = cfg_dst_addr[k*AW +: AW];
        ch_onehot[k] = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and bus/handshake outputs; everything is forced to 0 while
  // reset is high so nothing leaks out before the reset edge lands.
  always_comb begin
    state_d          = state_q;
    take_grant       = 1'b0;
    capture          = 1'b0;
    timeout          = 1'b0;
    finish           = 1'b0;
    bus_address      = '0;
    bus_write_data   = '0;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    irq_done         = '0;
    redirect         = 1'b0;
    redirect_pc      = '0;
    busy             = (state_q != IDLE);
    vec_full         = VEC_BASE + (64'(ch_q) * 64'(VEC_STRIDE));

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          take_grant = 1'b1;
          state_d    = RD;
        end
      end
      RD: begin
        bus_address     = src_sel;
        bus_read_enable = 1'b1;
        state_d         = WAIT;
      end
      WAIT: begin
        if (bus_read_valid) begin
          capture = 1'b1;
          state_d = WR;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        bus_address      = dst_sel;
        bus_write_data   = rd_data_q;
        bus_write_enable = 1'b1;
        irq_done         = ch_onehot;
        redirect         = 1'b1;
        redirect_pc      = AW'(vec_full);
        finish           = 1'b1;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      bus_address      = '0;
      bus_write_data   = '0;
      bus_write_enable = 1'b0;
      bus_read_enable  = 1'b0;
      irq_done         = '0;
      redirect         = 1'b0;
      redirect_pc      = '0;
      busy             = 1'b0;
    end
  end

  // Edge capture and pending bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      armed_q    <= 1'b0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_req;
      armed_q    <= 1'b1;
      pending_q  <= (pending_q & ~clr_mask) | irq_edge;
    end
  end

  // Transfer context: granted channel, arbitration pointer, wait counter,
  // captured read data and the registered timeout report.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q      <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      err_ch_q  <= '0;
    end else begin
      err_q <= timeout;
      if (timeout) begin
        err_ch_q <= ERR_CH_W'(ch_q);
      end
      if (take_grant) begin
        ch_q     <= arb_idx;
        rr_ptr_q <= next_ch(arb_idx, NCH);
      end
      if (state_q == RD) begin
        tmo_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (capture) begin
        rd_data_q <= bus_read_data;
      end
    end
  end

  assign err    = err_q && !reset;
  assign err_ch = reset ? '0 : err_ch_q;

endmodule

// File: tb/tb_irq_bus_mover.sv
// tb_irq_bus_mover: directed scenarios for irq_bus_mover with hand-computed
// expectations. Ordering expectations follow IRQM_RR_EN when it is defined.
module tb_irq_bus_mover;

  localparam int NCH = 4;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    irq_req;
  logic [NCH-1:0]    irq_mask;
  logic [NCH*AW-1:0] cfg_src_addr;
  logic [NCH*AW-1:0] cfg_dst_addr;
  logic [AW-1:0]     bus_address;
  logic [DW-1:0]     bus_write_data;
  logic              bus_write_enable;
  logic              bus_read_enable;
  logic [DW-1:0]     bus_read_data;
  logic              bus_read_valid;
  logic [NCH-1:0]    irq_done;
  logic              redirect;
  logic [AW-1:0]     redirect_pc;
  logic              busy;
  logic              err;
  logic [3:0]        err_ch;

  int n_compared;
  int n_mismatched;

  logic [AW-1:0] src_tab [NCH];
  logic [AW-1:0] dst_tab [NCH];

  irq_bus_mover #(
    .NCH(NCH), .AW(AW), .DW(DW), .TMO_CYC(8), .VEC_BASE(64'd0), .VEC_STRIDE(16)
  ) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data), .bus_read_valid(bus_read_valid),
    .irq_done(irq_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy), .err(err), .err_ch(err_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_req = 4'b1000; irq_mask = 4'hF;
    bus_read_valid = 1'b0; bus_read_data = '0;
    step(3);
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    n_compared++; if (bus_address !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_addr: got %h want 0", bus_address); end
    n_compared++; if (bus_write_data !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_wdata: got %h want 0", bus_write_data); end
    n_compared++; if ({bus_read_enable, bus_write_enable, redirect, err} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset_strobes: got %b want 0000", {bus_read_enable, bus_write_enable, redirect, err}); end
    n_compared++; if (irq_done !== 4'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0000", irq_done); end
    n_compared++; if (redirect_pc !== 64'h0 || err_ch !== 4'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc_errch: got %h/%h want 0/0", redirect_pc, err_ch); end
    // irq_req[3] is already high at release: must not start a transfer.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_compared++; if (busy !== 1'b0 || bus_read_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL level_not_edge cyc%0d: got busy=%0b rd=%0b want 0/0", i, busy, bus_read_enable); end
    end
    irq_req = '0;
    step(1);
  endtask

  task automatic test_single_transfer();
    irq_req = 4'b0010;                       // cycle 0: edge on ch1
    step(1); irq_req = '0;                   // cycle 1: pending latched, IDLE
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_idle_busy: got %0b want 0", busy); end
    step(1);                                 // cycle 2: RD
    n_compared++; if (bus_read_enable !== 1'b1 || bus_write_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_rd_en: got rd=%0b wr=%0b want 1/0", bus_read_enable, bus_write_enable); end
    n_compared++; if (bus_address !== 64'h8000_0010) begin n_mismatched++; $display("[TB] FAIL single_rd_addr: got %h want 80000010", bus_address); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_rd_busy: got %0b want 1", busy); end
    step(1);                                 // cycle 3: WAIT
    n_compared++; if (bus_read_enable !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_wait: got rd=%0b busy=%0b want 0/1", bus_read_enable, busy); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'hA5;  // cycle 4: data returns
    step(1); bus_read_valid = 1'b0; bus_read_data = '0;      // cycle 5: WR
    n_compared++; if (bus_write_enable !== 1'b1 || bus_read_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_wr_en: got wr=%0b rd=%0b want 1/0", bus_write_enable, bus_read_enable); end
    n_compared++; if (bus_address !== 64'h8000_0000) begin n_mismatched++; $display("[TB] FAIL single_wr_addr: got %h want 80000000", bus_address); end
    n_compared++; if (bus_write_data !== 64'hA5) begin n_mismatched++; $display("[TB] FAIL single_wr_data: got %h want a5", bus_write_data); end
    n_compared++; if (irq_done !== 4'b0010 || redirect !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_done: got done=%b redir=%0b want 0010/1", irq_done, redirect); end
    n_compared++; if (redirect_pc !== 64'h10) begin n_mismatched++; $display("[TB] FAIL single_pc: got %h want 10", redirect_pc); end
    step(1);                                 // cycle 6: back in IDLE
    n_compared++; if (busy !== 1'b0 || irq_done !== 4'b0 || redirect !== 1'b0 || bus_write_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_after: got busy=%0b done=%b redir=%0b wr=%0b want all 0", busy, irq_done, redirect, bus_write_enable); end
  endtask

  task automatic test_priority();
    int first_ch;
    int second_ch;
`ifdef IRQM_RR_EN
    first_ch = 2; second_ch = 0;
`else
    first_ch = 0; second_ch = 2;
`endif
    // Solo ch0 with data in the first WAIT cycle: best-case latency.
    irq_req = 4'b0001;                       // cycle 0
    step(1); irq_req = '0;                   // cycle 1
    step(1);                                 // cycle 2: RD
    n_compared++; if (bus_address !== 64'h1000 || bus_read_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL solo0_rd: got addr=%h rd=%0b want 1000/1", bus_address, bus_read_enable); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h11;  // cycle 3: WAIT+valid
    step(1); bus_read_valid = 1'b0;                          // cycle 4: WR
    n_compared++; if (irq_done !== 4'b0001 || bus_write_data !== 64'h11 || bus_address !== 64'h2000) begin n_mismatched++; $display("[TB] FAIL solo0_latency4: got done=%b data=%h addr=%h want 0001/11/2000", irq_done, bus_write_data, bus_address); end
    n_compared++; if (redirect_pc !== 64'h0 || redirect !== 1'b1) begin n_mismatched++; $display("[TB] FAIL solo0_pc: got pc=%h redir=%0b want 0/1", redirect_pc, redirect); end
    // ch0 and ch2 edges together.
    step(1); irq_req = 4'b0101;              // cycle 5
    step(1); irq_req = '0;                   // cycle 6
    step(1);                                 // cycle 7: RD for first
    n_compared++; if (bus_address !== src_tab[first_ch]) begin n_mismatched++; $display("[TB] FAIL prio_first_rd: got %h want %h", bus_address, src_tab[first_ch]); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h22;  // cycle 8
    step(1); bus_read_valid = 1'b0;                          // cycle 9: WR
    n_compared++; if (irq_done !== (4'b1 << first_ch) || bus_address !== dst_tab[first_ch]) begin n_mismatched++; $display("[TB] FAIL prio_first_done: got done=%b addr=%h want %b/%h", irq_done, bus_address, 4'b1 << first_ch, dst_tab[first_ch]); end
    step(1);                                 // cycle 10: IDLE
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL prio_gap_busy: got %0b want 0", busy); end
    step(1);                                 // cycle 11: RD for second
    n_compared++; if (bus_address !== src_tab[second_ch] || bus_read_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL prio_second_rd: got %h rd=%0b want %h/1", bus_address, bus_read_enable, src_tab[second_ch]); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h33;  // cycle 12
    step(1); bus_read_valid = 1'b0;                          // cycle 13: WR
    n_compared++; if (irq_done !== (4'b1 << second_ch) || bus_write_data !== 64'h33) begin n_mismatched++; $display("[TB] FAIL prio_second_done: got done=%b data=%h want %b/33", irq_done, bus_write_data, 4'b1 << second_ch); end
    n_compared++; if (redirect_pc !== 64'(second_ch * 16)) begin n_mismatched++; $display("[TB] FAIL prio_second_pc: got %h want %h", redirect_pc, second_ch * 16); end
    step(1);
  endtask

  task automatic test_timeout();
    irq_req = 4'b1000;                       // cycle 0
    step(1); irq_req = '0;                   // cycle 1
    step(1);                                 // cycle 2: RD
    n_compared++; if (bus_address !== 64'h1300 || bus_read_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tmo_rd: got addr=%h rd=%0b want 1300/1", bus_address, bus_read_enable); end
    for (int i = 0; i < 8; i++) begin        // cycles 3..10: WAIT, no valid
      step(1);
      n_compared++; if (busy !== 1'b1 || bus_write_enable !== 1'b0 || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tmo_wait cyc%0d: got busy=%0b wr=%0b err=%0b want 1/0/0", i, busy, bus_write_enable, err); end
    end
    step(1);                                 // cycle 11: err pulse
    n_compared++; if (err !== 1'b1 || err_ch !== 4'd3) begin n_mismatched++; $display("[TB] FAIL tmo_err: got err=%0b ch=%0d want 1/3", err, err_ch); end
    n_compared++; if (busy !== 1'b0 || bus_write_enable !== 1'b0 || redirect !== 1'b0 || irq_done !== 4'b0) begin n_mismatched++; $display("[TB] FAIL tmo_no_write: got busy=%0b wr=%0b redir=%0b done=%b want all 0", busy, bus_write_enable, redirect, irq_done); end
    step(1);
    n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tmo_err_pulse: got %0b want 0", err); end
    for (int i = 0; i < 3; i++) begin        // pending[3] cleared: no retry
      step(1);
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tmo_pending_cleared cyc%0d: got busy=%0b want 0", i, busy); end
    end
  endtask

  task automatic test_mask();
    irq_mask = 4'b1011;
    irq_req  = 4'b0100;
    step(1); irq_req = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n_compared++; if (busy !== 1'b0 || bus_read_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mask_hold cyc%0d: got busy=%0b rd=%0b want 0/0", i, busy, bus_read_enable); end
    end
    irq_mask = 4'hF;
    step(1);                                 // RD for ch2
    n_compared++; if (bus_address !== 64'h1100 || bus_read_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mask_rd: got addr=%h rd=%0b want 1100/1", bus_address, bus_read_enable); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h44;
    step(1); bus_read_valid = 1'b0;          // WR
    n_compared++; if (irq_done !== 4'b0100 || bus_write_data !== 64'h44 || bus_address !== 64'h2200) begin n_mismatched++; $display("[TB] FAIL mask_wr: got done=%b data=%h addr=%h want 0100/44/2200", irq_done, bus_write_data, bus_address); end
    n_compared++; if (redirect_pc !== 64'h20) begin n_mismatched++; $display("[TB] FAIL mask_pc: got %h want 20", redirect_pc); end
    step(1);
  endtask

  task automatic test_back_to_back();
    irq_req = 4'b0010;                       // cycle 0
    step(1); irq_req = '0;                   // cycle 1
    step(1);                                 // cycle 2: RD
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h55;  // cycle 3
    step(1); bus_read_valid = 1'b0; irq_req = 4'b0010;       // cycle 4: WR + new edge
    n_compared++; if (irq_done !== 4'b0010 || bus_write_data !== 64'h55) begin n_mismatched++; $display("[TB] FAIL b2b_first: got done=%b data=%h want 0010/55", irq_done, bus_write_data); end
    step(1); irq_req = '0;                   // cycle 5: IDLE
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_idle: got %0b want 0", busy); end
    step(1);                                 // cycle 6: RD again for ch1
    n_compared++; if (bus_read_enable !== 1'b1 || bus_address !== 64'h8000_0010) begin n_mismatched++; $display("[TB] FAIL b2b_reserve: got rd=%0b addr=%h want 1/80000010", bus_read_enable, bus_address); end
    step(1); bus_read_valid = 1'b1; bus_read_data = 64'h66;  // cycle 7
    step(1); bus_read_valid = 1'b0;                          // cycle 8: WR
    n_compared++; if (irq_done !== 4'b0010 || bus_write_data !== 64'h66 || bus_write_enable !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_second: got done=%b data=%h wr=%0b want 0010/66/1", irq_done, bus_write_data, bus_write_enable); end
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_settle cyc%0d: got busy=%0b want 0", i, busy); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    irq_req = 4'b0001;                       // cycle 0
    step(1); irq_req = '0;                   // cycle 1
    step(1);                                 // cycle 2: RD
    step(1);                                 // cycle 3: WAIT
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_mid_pre: got busy=%0b want 1", busy); end
    reset = 1'b1;
    #1;
    n_compared++; if (busy !== 1'b0 || err_ch !== 4'h0 || bus_address !== 64'h0 || bus_read_enable !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_gate: got busy=%0b errch=%h addr=%h rd=%0b want 0/0/0/0", busy, err_ch, bus_address, bus_read_enable); end
    step(1); reset = 1'b0; bus_read_valid = 1'b1; bus_read_data = 64'h77;
    for (int i = 0; i < 5; i++) begin
      step(1); bus_read_valid = 1'b0;
      n_compared++; if (bus_write_enable !== 1'b0 || busy !== 1'b0 || irq_done !== 4'b0 || redirect !== 1'b0 || bus_write_data !== 64'h0 || bus_address !== 64'h0) begin n_mismatched++; $display("[TB] FAIL rst_mid_after cyc%0d: got wr=%0b busy=%0b done=%b redir=%0b data=%h addr=%h want all 0", i, bus_write_enable, busy, irq_done, redirect, bus_write_data, bus_address); end
    end
    n_compared++; if (err_ch !== 4'h0 || err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_errch: got %h/%0b want 0/0", err_ch, err); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    src_tab[0] = 64'h1000; src_tab[1] = 64'h8000_0010; src_tab[2] = 64'h1100; src_tab[3] = 64'h1300;
    dst_tab[0] = 64'h2000; dst_tab[1] = 64'h8000_0000; dst_tab[2] = 64'h2200; dst_tab[3] = 64'h2300;
    cfg_src_addr   = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
    cfg_dst_addr   = {dst_tab[3], dst_tab[2], dst_tab[1], dst_tab[0]};
    reset          = 1'b1;
    irq_req        = '0;
    irq_mask       = 4'hF;
    bus_read_valid = 1'b0;
    bus_read_data  = '0;

    test_reset();
    test_single_transfer();
    test_priority();
    test_timeout();
    test_mask();
    test_back_to_back();
    test_reset_mid_transfer();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
